// File: rtl/demux_dispatch_ctrl_if.sv
// rtl/demux_dispatch_ctrl_if.sv - stream-in / one-hot-out bus of the 1:N demux dispatcher
interface demux_dispatch_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 6,
   parameter int SEL_W  = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [SEL_W-1:0]  in_sel;
   logic [N_OUT-1:0]  out_valid;
   logic [N_OUT-1:0]  out_ready;
   logic [DATA_W-1:0] out_data;
   logic [SEL_W-1:0]  out_ch;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// rtl/demux_dispatch_ctrl.sv - one-beat buffered 1:N dispatcher, round-robin or addressed
// Optional DEMUX_DISPATCH_STATS_EN adds beat_cnt / drop_cnt counters.
module demux_dispatch_ctrl #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 6,
   parameter int SEL_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   demux_dispatch_ctrl_if.slave bus,
   input  logic               mode,
   input  logic [N_OUT-1:0]   chan_en,
   input  logic               flush,
   output logic               err
`ifdef DEMUX_DISPATCH_STATS_EN
   ,
   output logic [15:0]        beat_cnt,
   output logic [7:0]         drop_cnt
`endif
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;
   localparam int         N_SEL   = 1 << SEL_W;

   logic [0:0]        state;
   logic [DATA_W-1:0] data_q;
   logic [SEL_W-1:0]  ch_q;
   logic [SEL_W-1:0]  last_ch;
   logic              err_q;

   logic              busy, can_take, complete, accept, drop;
   logic [SEL_W-1:0]  base, rr_tgt, tgt;
   logic [N_SEL-1:0]  en_pad, rdy_pad;

   assign en_pad   = N_SEL'(chan_en);
   assign rdy_pad  = N_SEL'(bus.out_ready);
   assign busy     = (state == ST_BUSY);
   assign complete = busy & rdy_pad[ch_q];
   assign can_take = mode | (|chan_en);
   assign bus.in_ready = can_take & (~busy | complete) & ~flush;
   assign accept   = bus.in_valid & bus.in_ready;

   // A completing beat advances the round-robin pointer for a same-cycle accept.
   assign base = complete ? ch_q : last_ch;

   always_comb begin
      rr_tgt = '0;
      for (int k = N_OUT; k >= 1; k--) begin
         if (chan_en[(int'(base) + k) % N_OUT])
            rr_tgt = SEL_W'((int'(base) + k) % N_OUT);
      end
   end

   assign tgt  = mode ? bus.in_sel : rr_tgt;
   assign drop = mode & ~en_pad[bus.in_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         data_q  <= '0;
         ch_q    <= '0;
         last_ch <= SEL_W'(N_OUT - 1);
         err_q   <= 1'b0;
      end else begin
         err_q <= accept & drop;
         if (complete)
            last_ch <= ch_q;
         if (flush) begin
            state <= ST_IDLE;
         end else if (accept & ~drop) begin
            state  <= ST_BUSY;
            data_q <= bus.in_data;
            ch_q   <= tgt;
         end else if (complete) begin
            state <= ST_IDLE;
         end
      end
   end

   assign bus.out_valid = busy ? (N_OUT'(1) << ch_q) : '0;
   assign bus.out_data  = data_q;
   assign bus.out_ch    = ch_q;
   assign err           = err_q;

`ifdef DEMUX_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         beat_cnt <= '0;
         drop_cnt <= '0;
      end else begin
         if (complete)
            beat_cnt <= beat_cnt + 16'd1;
         if (err_q && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb/tb_demux_dispatch_ctrl.sv - directed and random checks of demux_dispatch_ctrl against a transaction model
module tb_demux_dispatch_ctrl;
   localparam int DW = 8;
   localparam int N  = 6;
   localparam int SW = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         mode = 1'b0;
   logic         flush = 1'b0;
   logic [N-1:0] chan_en = '1;
   logic         err;
`ifdef DEMUX_DISPATCH_STATS_EN
   logic [15:0]  beat_cnt;
   logic [7:0]   drop_cnt;
`endif

   demux_dispatch_ctrl_if #(.DATA_W(DW), .N_OUT(N), .SEL_W(SW)) bus ();

   demux_dispatch_ctrl #(.DATA_W(DW), .N_OUT(N), .SEL_W(SW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .mode    (mode),
      .chan_en (chan_en),
      .flush   (flush),
      .err     (err)
`ifdef DEMUX_DISPATCH_STATS_EN
      ,
      .beat_cnt(beat_cnt),
      .drop_cnt(drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level reference: one held beat, its channel, the last served channel.
   bit       m_held;
   int       m_ch;
   int       m_last;
   logic [7:0] m_data;
   bit       m_err;
   int       m_beats;
   int       m_drops;

   int seen_ch[$];
   int err_pulses;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_ch = 0; m_last = N - 1; m_data = '0; m_err = 0;
      m_beats = 0; m_drops = 0;
   endtask

   task automatic cycle();
      bit can, rdy, comp, acc, bad;
      int base, tgt;
      logic [N-1:0] exp_valid;
      @(negedge clk);
      can  = mode || (chan_en != '0);
      comp = m_held && bus.out_ready[m_ch];
      rdy  = can && (!m_held || comp) && !flush;
      exp_valid = m_held ? (N'(1) << m_ch) : '0;
      chk("in_ready",  32'(bus.in_ready),  32'(rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
      chk("err",       32'(err),           32'(m_err));
`ifdef DEMUX_DISPATCH_STATS_EN
      chk("beat_cnt",  32'(beat_cnt),      32'(m_beats));
      chk("drop_cnt",  32'(drop_cnt),      32'(m_drops));
`endif
      if (bus.out_valid != '0) seen_ch.push_back(int'(bus.out_ch));
      if (err) err_pulses++;
      acc  = bus.in_valid && rdy;
      base = comp ? m_ch : m_last;
      bad  = 0;
      tgt  = 0;
      if (mode) begin
         tgt = int'(bus.in_sel);
         bad = (tgt >= N) || !chan_en[tgt];
      end else begin
         for (int k = 1; k <= N; k++) begin
            if (chan_en[(base + k) % N]) begin
               tgt = (base + k) % N;
               break;
            end
         end
      end
      @(posedge clk);
      if (flush) begin
         m_beats = 0; m_drops = 0;
      end else begin
         if (comp) m_beats = (m_beats + 1) % 65536;
         if (m_err && m_drops < 255) m_drops++;
      end
      if (comp) m_last = m_ch;
      m_err = acc && bad;
      if (flush) m_held = 0;
      else if (acc && !bad) begin
         m_held = 1; m_ch = tgt; m_data = bus.in_data;
      end else if (comp) m_held = 0;
      #1;
   endtask

   initial begin
      int exp_rr[8];
      int exp_rr2[4];
      exp_rr  = '{0, 1, 2, 3, 4, 5, 0, 1};
      exp_rr2 = '{2, 5, 2, 5};
      bus.in_valid = 0; bus.in_data = '0; bus.in_sel = '0; bus.out_ready = '1;
      model_reset();
      err_pulses = 0;

      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data",  32'(bus.out_data),  32'h0);
      chk("rst_out_ch",    32'(bus.out_ch),    32'h0);
      chk("rst_err",       32'(err),           32'h0);
      @(posedge clk); #1;
      rst_n = 1;

      // Round-robin over all channels, full throughput.
      mode = 0; chan_en = 6'b111111; bus.out_ready = '1;
      seen_ch.delete();
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1; bus.in_data = 8'(8'h10 + i);
         cycle();
      end
      bus.in_valid = 0;
      repeat (2) cycle();
      chk("rr_count", 32'(seen_ch.size()), 32'd8);
      for (int i = 0; i < 8 && i < seen_ch.size(); i++) chk("rr_seq", 32'(seen_ch[i]), 32'(exp_rr[i]));

      // Sparse enable mask, then empty mask stalls the input.
      chan_en = 6'b100100;
      seen_ch.delete();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1; bus.in_data = 8'(8'h20 + i);
         cycle();
      end
      bus.in_valid = 0;
      repeat (2) cycle();
      chk("rr2_count", 32'(seen_ch.size()), 32'd4);
      for (int i = 0; i < 4 && i < seen_ch.size(); i++) chk("rr2_seq", 32'(seen_ch[i]), 32'(exp_rr2[i]));
      chan_en = '0; bus.in_valid = 1;
      repeat (10) cycle();
      bus.in_valid = 0;

      // Addressed mode: one delivery, two drops.
      mode = 1; chan_en = 6'b101111;
      seen_ch.delete(); err_pulses = 0;
      bus.in_valid = 1; bus.in_data = 8'h31; bus.in_sel = 3'd3; cycle();
      bus.in_data = 8'h32; bus.in_sel = 3'd7; cycle();
      bus.in_data = 8'h33; bus.in_sel = 3'd4; cycle();
      bus.in_valid = 0;
      repeat (3) cycle();
      chk("addr_deliv", 32'(seen_ch.size()), 32'd1);
      if (seen_ch.size() > 0) chk("addr_ch", 32'(seen_ch[0]), 32'd3);
      chk("addr_err", 32'(err_pulses), 32'd2);

      // Backpressure on channel 1; other channels' ready is ignored.
      chan_en = '1; bus.out_ready = 6'b000001;
      bus.in_valid = 1; bus.in_data = 8'hA5; bus.in_sel = 3'd1; cycle();
      bus.in_data = 8'h5A; bus.in_sel = 3'd2;
      repeat (5) cycle();
      bus.out_ready = 6'b000010; cycle();
      bus.in_valid = 0; bus.out_ready = '1;
      repeat (2) cycle();

      // Flush while busy, then asynchronous reset mid-transfer.
      mode = 0; err_pulses = 0; bus.out_ready = '0;
      bus.in_valid = 1; bus.in_data = 8'h33; cycle();
      bus.in_valid = 0; cycle();
      flush = 1; cycle();
      flush = 0; cycle();
      chk("flush_no_err", 32'(err_pulses), 32'd0);
      bus.in_valid = 1; bus.in_data = 8'h44; cycle();
      bus.in_valid = 0; cycle();
      rst_n = 0; #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_out_data",  32'(bus.out_data),  32'h0);
      chk("arst_out_ch",    32'(bus.out_ch),    32'h0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      bus.out_ready = '1; seen_ch.delete();
      bus.in_valid = 1; bus.in_data = 8'h55; cycle();
      bus.in_valid = 0; repeat (2) cycle();
      if (seen_ch.size() > 0) chk("post_rst_ch", 32'(seen_ch[0]), 32'd0);
      else chk("post_rst_deliv", 32'(seen_ch.size()), 32'd1);

`ifdef DEMUX_DISPATCH_STATS_EN
      flush = 1; cycle(); flush = 0;
      mode = 1; chan_en = '1; bus.in_valid = 1; bus.in_sel = 3'd7;
      repeat (300) cycle();
      bus.in_sel = 3'd0;
      for (int i = 0; i < 5; i++) begin
         bus.in_data = 8'(i); cycle();
      end
      bus.in_valid = 0; repeat (3) cycle();
      chk("stat_drop", 32'(drop_cnt), 32'd255);
      chk("stat_beat", 32'(beat_cnt), 32'd5);
      flush = 1; cycle(); flush = 0; cycle();
      chk("stat_clr_drop", 32'(drop_cnt), 32'd0);
      chk("stat_clr_beat", 32'(beat_cnt), 32'd0);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if (i % 50 == 0) begin
            mode    = 1'($urandom);
            chan_en = ($urandom % 6 == 0) ? '0 : N'($urandom);
         end
         bus.in_valid  = ($urandom % 4) != 0;
         bus.in_data   = DW'($urandom);
         bus.in_sel    = SW'($urandom);
         bus.out_ready = N'($urandom);
         flush         = ($urandom % 25) == 0;
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
